// File: rtl/fetch_sequencer.sv
// Fetch PC owner and IF/ID sequencer: next-PC select, stall/redirect arbitration, halt drain.
// Latency: PCF is registered (one edge); stallF/stallD/flushD are combinational, used at the same edge.
// Backpressure: mem_busy freezes the front end; lw_hazard replays IF/ID for one cycle.
//
// Ports:
//   Clock, RESET          rising-edge clock, synchronous active-high reset
//   mem_busy, lw_hazard   stall requests (data memory not ready, load-use)
//   PCSrcD                000 seq, 001 branch, 010 j, 011 jr, 100 jal, 101-111 seq
//   PCBranchD/PCJumpD/PCJrD  redirect targets from the ID stage
//   InstructionF          fetched word, only inspected for the halt encoding
//   PCF, PCnormalF, FETCH_ADDRESS  fetch PC, PC+4, word address to InstructionRAM
//   stallF, stallD, flushD          IF / IF-ID controls
//   halted, state         sticky drained flag and debug state (00 RUN, 01 STALL, 10 DRAIN, 11 HALT)
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic        Clock,
  input  logic        RESET,
  input  logic        mem_busy,
  input  logic        lw_hazard,
  input  logic [2:0]  PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] PCJumpD,
  input  logic [31:0] PCJrD,
  input  logic [31:0] InstructionF,
  output logic [31:0] PCF,
  output logic [31:0] PCnormalF,
  output logic [31:0] FETCH_ADDRESS,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        halted,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_DRAIN = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  // Counter must hold DRAIN_CYCLES-1; keep at least one bit when DRAIN_CYCLES==1.
  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            cur_state;
  state_t            nxt_state;
  logic [31:0]       pc_q;
  logic [31:0]       pc_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nxt;

  logic              redirect;
  logic [31:0]       target_raw;
  logic [31:0]       target;
  logic [31:0]       pc_seq;
  logic              halt_hit;

  // ------------------------------------------------------------------
  // Redirect decode and target select
  // ------------------------------------------------------------------
  always_comb begin
    redirect   = 1'b0;
    target_raw = PCBranchD;
    case (PCSrcD)
      3'b001: begin
        redirect   = 1'b1;
        target_raw = PCBranchD;
      end
      3'b010, 3'b100: begin
        redirect   = 1'b1;
        target_raw = PCJumpD;
      end
      3'b011: begin
        redirect   = 1'b1;
        target_raw = PCJrD;
      end
      default: begin
        redirect   = 1'b0;
        target_raw = PCBranchD;
      end
    endcase
  end

  // Fetch is word-aligned; a misaligned target is silently truncated.
  assign target   = {target_raw[31:2], 2'b00};
  assign pc_seq   = pc_q + 32'd4;   // wraps modulo 2^32
  assign halt_hit = (InstructionF == HALT_WORD);

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge Clock) begin
    if (RESET) begin
      cur_state <= ST_RUN;
      pc_q      <= RESET_PC;
      cnt_q     <= '0;
    end else begin
      cur_state <= nxt_state;
      pc_q      <= pc_nxt;
      cnt_q     <= cnt_nxt;
    end
  end

  // ------------------------------------------------------------------
  // Next state, next PC and IF/ID controls
  // ------------------------------------------------------------------
  always_comb begin
    nxt_state = cur_state;
    pc_nxt    = pc_q;
    cnt_nxt   = cnt_q;
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;

    case (cur_state)
      ST_RUN, ST_STALL: begin
        if (mem_busy) begin
          // Whole front end frozen; nothing may move into or out of IF/ID.
          stallF    = 1'b1;
          stallD    = 1'b1;
          nxt_state = ST_STALL;
        end else begin
          // STALL releases straight into the RUN decision in the same cycle.
          nxt_state = ST_RUN;
          if (lw_hazard) begin
            // Redirect is ignored: the instruction in D is replayed and
            // resolves its branch again next cycle with correct operands.
            stallF = 1'b1;
            stallD = 1'b1;
          end else if (redirect) begin
            // Redirect beats a halt word in IF: that word is on the wrong path.
            pc_nxt = target;
            flushD = 1'b1;
          end else if (halt_hit) begin
            stallF    = 1'b1;
            flushD    = 1'b1;
            cnt_nxt   = CNT_INIT;
            nxt_state = ST_DRAIN;
          end else begin
            pc_nxt = pc_seq;
          end
        end
      end

      ST_DRAIN: begin
        // Bubbles push the older instructions out of the back end.
        stallF = 1'b1;
        flushD = 1'b1;
        if (!mem_busy) begin
          if (cnt_q == '0) begin
            nxt_state = ST_HALT;
          end else begin
            cnt_nxt = cnt_q - CNT_ONE;
          end
        end
      end

      ST_HALT: begin
        stallF = 1'b1;
        flushD = 1'b1;
      end

      default: begin
        nxt_state = ST_RUN;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign PCF           = pc_q;
  assign PCnormalF     = pc_seq;
  assign FETCH_ADDRESS = {2'b00, pc_q[31:2]};
  assign halted        = (cur_state == ST_HALT);
  assign state         = cur_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam int          DRAIN_CYCLES = 4;
  localparam logic [31:0] HALT_WORD    = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  localparam int M_RUN = 0, M_STALL = 1, M_DRAIN = 2, M_HALT = 3;

  logic        Clock = 1'b0;
  logic        RESET;
  logic        mem_busy;
  logic        lw_hazard;
  logic [2:0]  PCSrcD;
  logic [31:0] PCBranchD, PCJumpD, PCJrD, InstructionF;
  logic [31:0] PCF, PCnormalF, FETCH_ADDRESS;
  logic        stallF, stallD, flushD, halted;
  logic [1:0]  state;

  fetch_sequencer #(
    .RESET_PC(RESET_PC), .DRAIN_CYCLES(DRAIN_CYCLES), .HALT_WORD(HALT_WORD)
  ) dut (
    .Clock(Clock), .RESET(RESET), .mem_busy(mem_busy), .lw_hazard(lw_hazard),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .PCJumpD(PCJumpD), .PCJrD(PCJrD),
    .InstructionF(InstructionF), .PCF(PCF), .PCnormalF(PCnormalF),
    .FETCH_ADDRESS(FETCH_ADDRESS), .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .halted(halted), .state(state)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: architectural view of the front end.
  logic [31:0] m_pc;
  int          m_mode;
  int          m_left;   // drain bubbles still to be issued

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  // Called at the falling edge; returns at the next falling edge.
  task automatic cyc(input logic r, input logic b, input logic l, input logic [2:0] s,
                     input logic [31:0] br, input logic [31:0] jp, input logic [31:0] jr,
                     input logic [31:0] ins);
    logic        e_sf, e_sd, e_fd, redir;
    logic [31:0] tgt, n_pc;
    int          n_mode, n_left;
    RESET = r; mem_busy = b; lw_hazard = l; PCSrcD = s;
    PCBranchD = br; PCJumpD = jp; PCJrD = jr; InstructionF = ins;

    redir = (s >= 3'd1) && (s <= 3'd4);
    tgt   = (s == 3'd1) ? br : ((s == 3'd3) ? jr : jp);
    tgt   = tgt & 32'hFFFF_FFFC;
    e_sf = 0; e_sd = 0; e_fd = 0;
    n_pc = m_pc; n_mode = m_mode; n_left = m_left;

    if (m_mode == M_HALT) begin
      e_sf = 1; e_fd = 1;
    end else if (m_mode == M_DRAIN) begin
      e_sf = 1; e_fd = 1;
      if (!b) begin
        n_left = m_left - 1;
        if (n_left == 0) n_mode = M_HALT;
      end
    end else if (b) begin
      e_sf = 1; e_sd = 1; n_mode = M_STALL;
    end else begin
      n_mode = M_RUN;
      if (l) begin
        e_sf = 1; e_sd = 1;
      end else if (redir) begin
        e_fd = 1; n_pc = tgt;
      end else if (ins == HALT_WORD) begin
        e_sf = 1; e_fd = 1; n_mode = M_DRAIN; n_left = DRAIN_CYCLES;
      end else begin
        n_pc = m_pc + 32'd4;
      end
    end

    #1;
    chk("pcf", PCF, m_pc);
    chk("pcnormal", PCnormalF, m_pc + 32'd4);
    chk("fetch_addr", FETCH_ADDRESS, m_pc / 4);
    chk("state", {30'd0, state}, m_mode);
    chk("halted", {31'd0, halted}, (m_mode == M_HALT) ? 1 : 0);
    if (!r) begin
      chk("stallF", {31'd0, stallF}, {31'd0, e_sf});
      chk("stallD", {31'd0, stallD}, {31'd0, e_sd});
      chk("flushD", {31'd0, flushD}, {31'd0, e_fd});
    end

    @(posedge Clock);
    if (r) begin
      m_pc = RESET_PC; m_mode = M_RUN; m_left = 0;
    end else begin
      m_pc = n_pc; m_mode = n_mode; m_left = n_left;
    end
    @(negedge Clock);
  endtask

  task automatic idle(input logic [31:0] ins);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, ins);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, NOP);
  endtask

  initial begin
    RESET = 1'b1; mem_busy = 0; lw_hazard = 0; PCSrcD = 0;
    PCBranchD = 0; PCJumpD = 0; PCJrD = 0; InstructionF = NOP;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    RESET = 1'b0;
    m_pc = RESET_PC; m_mode = M_RUN; m_left = 0;
    #1;
    chk("rst_pc", PCF, 32'h0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_ctl", {29'd0, stallF, stallD, flushD}, 32'd0);

    // Sequential fetch after reset.
    for (int i = 0; i < 5; i++) begin
      chk("idle_pc", PCF, 32'(i * 4));
      chk("idle_fa", FETCH_ADDRESS, 32'(i));
      idle(NOP);
    end

    // Branch at PCF=8.
    do_reset(); idle(NOP); idle(NOP);
    chk("br_pc8", PCF, 32'h8);
    cyc(0, 0, 0, 3'b001, 32'h40, 32'h0, 32'h0, NOP);
    chk("br_tgt", PCF, 32'h40);
    idle(NOP);
    chk("br_seq", PCF, 32'h44);

    // Load-use at PCF=12, with a redirect that must be ignored.
    do_reset(); repeat (3) idle(NOP);
    cyc(0, 0, 1, 3'b010, 32'h0, 32'h200, 32'h0, NOP);
    chk("lw_hold", PCF, 32'd12);
    idle(NOP);
    chk("lw_next", PCF, 32'd16);

    // mem_busy for 3 cycles with jr held, then release.
    repeat (3) begin
      cyc(0, 1, 0, 3'b011, 32'h0, 32'h0, 32'h100, NOP);
      chk("busy_state", {30'd0, state}, 32'd1);
      chk("busy_pc", PCF, 32'd16);
    end
    cyc(0, 0, 0, 3'b011, 32'h0, 32'h0, 32'h100, NOP);
    chk("busy_jr", PCF, 32'h100);

    // Misaligned jump target and PC wrap.
    cyc(0, 0, 0, 3'b100, 32'h0, 32'hFFFF_FFFF, 32'h0, NOP);
    chk("wrap_tgt", PCF, 32'hFFFF_FFFC);
    idle(NOP);
    chk("wrap_pc", PCF, 32'h0);

    // Redirect and halt word together: redirect wins.
    cyc(0, 0, 0, 3'b001, 32'h80, 32'h0, 32'h0, HALT_WORD);
    chk("br_vs_halt_pc", PCF, 32'h80);
    chk("br_vs_halt_st", {30'd0, state}, 32'd0);

    // Halt at PCF=0x20: four drain cycles, then sticky HALT.
    do_reset(); repeat (8) idle(NOP);
    idle(HALT_WORD);
    for (int i = 0; i < DRAIN_CYCLES; i++) begin
      chk("drain_state", {30'd0, state}, 32'd2);
      idle(HALT_WORD);
    end
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pc", PCF, 32'h20);
    repeat (3) cyc(0, 0, 1, 3'b010, 32'h0, 32'h400, 32'h0, NOP);
    chk("halt_sticky", PCF, 32'h20);

    // Reset out of HALT.
    do_reset();
    chk("unhalt_pc", PCF, 32'h0);
    chk("unhalt_flag", {31'd0, halted}, 32'd0);
    chk("unhalt_state", {30'd0, state}, 32'd0);

    // mem_busy mid-drain delays halted by the busy length.
    repeat (8) idle(NOP);
    idle(HALT_WORD);
    idle(HALT_WORD); idle(HALT_WORD);
    repeat (3) cyc(0, 1, 0, 3'd0, 32'h0, 32'h0, 32'h0, HALT_WORD);
    idle(HALT_WORD);
    chk("drain_busy_st", {30'd0, state}, 32'd2);
    idle(HALT_WORD);
    chk("drain_busy_halt", {31'd0, halted}, 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      logic        r, b, l;
      logic [2:0]  s;
      logic [31:0] ins;
      r   = (m_mode == M_HALT) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      b   = ($urandom_range(0, 4) == 0);
      l   = ($urandom_range(0, 5) == 0);
      s   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
      ins = ($urandom_range(0, 24) == 0) ? HALT_WORD : $urandom;
      cyc(r, b, l, s, $urandom, $urandom, $urandom, ins);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
